// File: rtl/abc.sv
// BCD adder with SOC/EOC handshakes to two converter-style producers and a
// dav_/rfd handshake to one consumer. Every output is driven from a flop.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | wait for both producers idle (eoc high), then raise soc
// S_START | hold soc until each eoc has been seen low, then drop soc
// S_WAIT  | wait until each eoc has been seen high, capture a and b
// S_CALC  | split a+b into tens/units digits
// S_OUT   | wait for consumer ready, then assert davC_
// S_ACK   | hold davC_ low until consumer drops rfdC
module abc (
   input  logic       clock,
   input  logic       reset_,
   input  logic       eocA,
   input  logic [3:0] a,
   output logic       socA,
   input  logic       eocB,
   input  logic [3:0] b,
   output logic       socB,
   input  logic       rfdC,
   output logic       davC_,
   output logic [3:0] z1,
   output logic [3:0] z0
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_CALC  = 3'd3,
      S_OUT   = 3'd4,
      S_ACK   = 3'd5
   } state_t;

   state_t     state;
   logic       seen_a;
   logic       seen_b;
   logic [3:0] a_reg;
   logic [3:0] b_reg;

   logic [4:0] sum;
   logic [3:0] tens;
   logic [3:0] units;
   logic       start_done;
   logic       wait_done;

   // Digit split by range compare; the 5-bit sum never exceeds 30.
   always_comb begin
      sum   = {1'b0, a_reg} + {1'b0, b_reg};
      tens  = 4'd0;
      units = sum[3:0];
      if (sum >= 5'd30) begin
         tens  = 4'd3;
         units = 4'(sum - 5'd30);
      end else if (sum >= 5'd20) begin
         tens  = 4'd2;
         units = 4'(sum - 5'd20);
      end else if (sum >= 5'd10) begin
         tens  = 4'd1;
         units = 4'(sum - 5'd10);
      end
   end

   // Each producer's edge is remembered, so drop/rise order does not matter.
   always_comb begin
      start_done = (seen_a || !eocA) && (seen_b || !eocB);
      wait_done  = (seen_a ||  eocA) && (seen_b ||  eocB);
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state  <= S_IDLE;
         seen_a <= 1'b0;
         seen_b <= 1'b0;
         a_reg  <= 4'd0;
         b_reg  <= 4'd0;
         socA   <= 1'b0;
         socB   <= 1'b0;
         davC_  <= 1'b1;
         z1     <= 4'd0;
         z0     <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               seen_a <= 1'b0;
               seen_b <= 1'b0;
               if (eocA && eocB) begin
                  socA  <= 1'b1;
                  socB  <= 1'b1;
                  state <= S_START;
               end
            end
            S_START: begin
               if (start_done) begin
                  socA   <= 1'b0;
                  socB   <= 1'b0;
                  seen_a <= 1'b0;
                  seen_b <= 1'b0;
                  state  <= S_WAIT;
               end else begin
                  if (!eocA) seen_a <= 1'b1;
                  if (!eocB) seen_b <= 1'b1;
               end
            end
            S_WAIT: begin
               if (wait_done) begin
                  a_reg  <= a;
                  b_reg  <= b;
                  seen_a <= 1'b0;
                  seen_b <= 1'b0;
                  state  <= S_CALC;
               end else begin
                  if (eocA) seen_a <= 1'b1;
                  if (eocB) seen_b <= 1'b1;
               end
            end
            S_CALC: begin
               z1    <= tens;
               z0    <= units;
               state <= S_OUT;
            end
            S_OUT: begin
               if (rfdC) begin
                  davC_ <= 1'b0;
                  state <= S_ACK;
               end
            end
            S_ACK: begin
               if (!rfdC) begin
                  davC_ <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               socA  <= 1'b0;
               socB  <= 1'b0;
               davC_ <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_abc.sv
// Directed and randomized transactions for abc; producers and consumer are
// played by the bench, results are checked against plain a+b arithmetic.
module tb_abc;

   logic       clock = 1'b0;
   logic       reset_ = 1'b0;
   logic       eocA = 1'b1;
   logic       eocB = 1'b1;
   logic       rfdC = 1'b1;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic       socA, socB, davC_;
   logic [3:0] z1, z0;

   int n_checks = 0;
   int n_pass = 0;

   abc dut (
      .clock (clock),
      .reset_(reset_),
      .eocA  (eocA),
      .a     (a),
      .socA  (socA),
      .eocB  (eocB),
      .b     (b),
      .socB  (socB),
      .rfdC  (rfdC),
      .davC_ (davC_),
      .z1    (z1),
      .z0    (z0)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One full handshake cycle. Delays are in clocks after the relevant soc edge.
   task automatic txn(input logic [3:0] va, input logic [3:0] vb,
                      input int dA, input int dB, input int rA, input int rB,
                      input bit rfd_early, input string tag);
      int n;
      int total;
      int exp_tens;
      int exp_units;
      total     = int'(va) + int'(vb);
      exp_tens  = total / 10;
      exp_units = total % 10;
      rfdC = rfd_early;

      n = 0;
      while (!(socA || socB) && n < 20) begin @(negedge clock); n++; end
      check({tag, "_soc_rise"}, {6'd0, socA, socB}, 8'b11);

      for (int k = 1; k <= ((dA > dB) ? dA : dB); k++) begin
         @(negedge clock);
         if (k == dA) begin eocA = 1'b0; a = 'x; end
         if (k == dB) begin eocB = 1'b0; b = 'x; end
      end

      n = 0;
      while ((socA || socB) && n < 20) begin
         @(negedge clock);
         n++;
         if (socA !== socB) check({tag, "_soc_fall_together"}, {7'd0, socA}, {7'd0, socB});
      end
      check({tag, "_soc_fall"}, {6'd0, socA, socB}, 8'b00);

      for (int k = 1; k <= ((rA > rB) ? rA : rB); k++) begin
         @(negedge clock);
         if (k == rA) begin eocA = 1'b1; a = va; end
         if (k == rB) begin eocB = 1'b1; b = vb; end
      end

      if (!rfd_early) begin
         repeat (5) @(negedge clock);
         check({tag, "_stall_dav"}, {7'd0, davC_}, 8'd1);
         rfdC = 1'b1;
      end

      n = 0;
      while (davC_ && n < 20) begin @(negedge clock); n++; end
      check({tag, "_dav_latency"}, 8'(n), rfd_early ? 8'd3 : 8'd1);
      check({tag, "_z1"}, {4'd0, z1}, 8'(exp_tens));
      check({tag, "_z0"}, {4'd0, z0}, 8'(exp_units));

      a = 'x;
      b = 'x;
      repeat (2) @(negedge clock);
      check({tag, "_hold"}, {davC_, 3'd0, z1 ^ z0}, {1'b0, 3'd0, 4'(exp_tens ^ exp_units)});
      check({tag, "_hold_z0"}, {4'd0, z0}, 8'(exp_units));

      rfdC = 1'b0;
      @(negedge clock);
      check({tag, "_dav_release"}, {7'd0, davC_}, 8'd1);
   endtask

   initial begin
      int n;
      int v;

      reset_ = 1'b0;
      eocA = 1'b1; eocB = 1'b1; rfdC = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_outs", {5'd0, socA, socB, davC_}, 8'b001);
      check("reset_z", {z1, z0}, 8'h00);

      reset_ = 1'b1;
      n = 0;
      while (!(socA && socB) && n < 20) begin @(negedge clock); n++; end
      check("reset_release_soc", {7'd0, (n >= 1 && n <= 2)}, 8'd1);

      txn(4'd9, 4'd5, 1, 2, 1, 2, 1'b1, "single_9_5");
      txn(4'd9, 4'd9, 2, 1, 3, 1, 1'b1, "max_9_9");
      txn(4'd0, 4'd0, 1, 1, 1, 1, 1'b1, "zero_0_0");
      txn(4'd4, 4'd7, 1, 3, 2, 4, 1'b0, "stall_4_7");

      for (int i = 0; i < 32; i++) begin
         v = ((i + 5) * 19) % 100;
         txn(4'(v / 10), 4'(v % 10), 1, $urandom_range(2, 5), 1, $urandom_range(2, 6),
             1'b1, $sformatf("seq%0d", i));
      end

      // Mid-operation reset while soc is high.
      rfdC = 1'b1;
      n = 0;
      while (!(socA && socB) && n < 20) begin @(negedge clock); n++; end
      check("midrst_soc_high", {6'd0, socA, socB}, 8'b11);
      eocA = 1'b0;
      @(negedge clock);
      reset_ = 1'b0;
      #1;
      check("midrst_async", {5'd0, socA, socB, davC_}, 8'b001);
      eocA = 1'b1;
      repeat (2) @(negedge clock);
      reset_ = 1'b1;
      txn(4'd3, 4'd8, 2, 2, 1, 3, 1'b1, "after_reset");

      for (int i = 0; i < 16; i++) begin
         txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(1, 4), $urandom_range(1, 4),
             $urandom_range(1, 5), $urandom_range(1, 5),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
